// File: rtl/tvm_mmap_pkg.sv
// Shared types and helpers for the mmap copy engine: FSM state encoding and
// the length clamp limit derived from the mmap offset width.
package tvm_mmap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Largest copy length an mmap region with 'aw' offset bits can hold.
  function automatic int unsigned len_max(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/tvm_mmap_copy_engine_addr_gen.sv
// Offset sequencer: read offset counter, remaining-unit counter and the
// one-cycle delay stage that turns read issues into write address/enable.
module tvm_mmap_addr_gen
  import tvm_mmap_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH:0]   i_len,
  input  logic                  i_issue,
  input  logic                  i_kill,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_last,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_wr_en
);

  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH:0]   r_remain;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic                  r_wr_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_addr <= '0;
      r_remain  <= '0;
      r_wr_addr <= '0;
      r_wr_en   <= 1'b0;
    end else begin
      if (i_load) begin
        r_rd_addr <= '0;
        r_remain  <= i_len;
      end else if (i_issue) begin
        r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
        r_remain  <= r_remain - (ADDR_WIDTH + 1)'(1);
      end
      // A cancelled copy must not write the offset issued on the abort cycle.
      r_wr_en   <= i_issue && !i_kill;
      r_wr_addr <= r_rd_addr;
    end
  end

  assign o_rd_addr = r_rd_addr;
  assign o_last    = (r_remain == (ADDR_WIDTH + 1)'(1));
  assign o_wr_addr = r_wr_addr;
  assign o_wr_en   = r_wr_en;

endmodule

// File: rtl/tvm_mmap_copy_engine.sv
// Block copy engine driving a read-only and a write-only mmap port.
// Optional running checksum of written data: define TVM_MMAP_COPY_CHECKSUM_EN.
module tvm_mmap_copy_engine
  import tvm_mmap_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 8,
  parameter int BASE_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [BASE_ADDR_WIDTH-1:0] src_base,
  input  logic [BASE_ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH:0]        len,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_WIDTH-1:0]      rd_addr,
  input  logic [DATA_WIDTH-1:0]      rd_data,
  output logic [BASE_ADDR_WIDTH-1:0] rd_mmap_addr,
  output logic [ADDR_WIDTH-1:0]      wr_addr,
  output logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       wr_en,
  output logic [BASE_ADDR_WIDTH-1:0] wr_mmap_addr,
  output logic [1:0]                 o_dbg_state
`ifdef TVM_MMAP_COPY_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]      checksum
`endif
);

  localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH + 1)'(len_max(ADDR_WIDTH));

  // Control protocol: start is a one-cycle request honoured only in IDLE;
  // done is a one-cycle completion pulse; busy covers RUN and DRAIN.
  state_t                     r_state;
  logic                       r_busy;
  logic                       r_done;
  logic [BASE_ADDR_WIDTH-1:0] r_rd_base;
  logic [BASE_ADDR_WIDTH-1:0] r_wr_base;

  logic [ADDR_WIDTH:0]        w_len_clamped;
  logic                       w_accept;
  logic                       w_issue;
  logic                       w_kill;
  logic                       w_last;
  logic                       w_wr_en;

  assign w_len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
  assign w_accept      = (r_state == IDLE) && start;
  assign w_issue       = (r_state == RUN);
  assign w_kill        = abort && ((r_state == RUN) || (r_state == DRAIN));

  tvm_mmap_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_accept),
    .i_len    (w_len_clamped),
    .i_issue  (w_issue),
    .i_kill   (w_kill),
    .o_rd_addr(rd_addr),
    .o_last   (w_last),
    .o_wr_addr(wr_addr),
    .o_wr_en  (w_wr_en)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_base <= '0;
      r_wr_base <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_rd_base <= src_base;
            r_wr_base <= dst_base;
            if (w_len_clamped == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_last) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_busy <= 1'b0;
          if (abort) begin
            r_state <= IDLE;
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TVM_MMAP_COPY_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= '0;
    end else if (w_wr_en) begin
      r_checksum <= r_checksum + rd_data;
    end
  end

  assign checksum = r_checksum;
`endif

  assign busy         = r_busy;
  assign done         = r_done;
  assign wr_en        = w_wr_en;
  assign wr_data      = rd_data;
  assign rd_mmap_addr = r_rd_base;
  assign wr_mmap_addr = r_wr_base;
  assign o_dbg_state  = r_state;

endmodule

// File: doc/tvm_mmap_copy_engine.md
Name: tvm_mmap_copy_engine

Overview:
- Initiator-side driver for the read-only and write-only mmap ports.
- Moves a block of `len` units from a source mmap region to a destination mmap region.
  - Issues sequential local offsets to the read port, which has one-cycle read latency.
  - Forwards the returned data to the write port, which performs one-cycle writes.
- Sits between test/control logic and the mmap instances that are passed to $tvm_session, so testcases can run DRAM-to-DRAM copies without hand-written address sequencing.

Parameters:
- DATA_WIDTH, 8, width of one unit; must match both mmap instances.
- ADDR_WIDTH, 8, local offset width of the mmap ports.
- BASE_ADDR_WIDTH, 32, width of the mmap base addresses.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- abort  input  1  cancel an in-flight copy.
- src_base  input  BASE_ADDR_WIDTH  source base address, latched on start.
- dst_base  input  BASE_ADDR_WIDTH  destination base address, latched on start.
- len  input  ADDR_WIDTH+1  number of units, 0..2^ADDR_WIDTH.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse when a copy completes.
- rd_addr  output  ADDR_WIDTH  read-port local offset.
- rd_data  input  DATA_WIDTH  read-port data, valid the cycle after rd_addr.
- rd_mmap_addr  output  BASE_ADDR_WIDTH  read-port base address.
- wr_addr  output  ADDR_WIDTH  write-port local offset.
- wr_data  output  DATA_WIDTH  write-port data.
- wr_en  output  1  write-port enable.
- wr_mmap_addr  output  BASE_ADDR_WIDTH  write-port base address.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - State is IDLE.
  - busy, done, wr_en are 0.
  - rd_addr, wr_addr, rd_mmap_addr, wr_mmap_addr are 0.
  - Internal counters are 0.
- States:
  - IDLE: on start=1 at edge T, latch the bases into rd_mmap_addr/wr_mmap_addr and latch len.
    - If len>2^ADDR_WIDTH, clamp it to 2^ADDR_WIDTH.
    - Set rd_addr=0.
    - Go to RUN, or go to DONE if len==0.
  - RUN: one issue per cycle, no stalls.
    - rd_addr increments each cycle.
    - A remaining-count register decrements.
    - On the cycle that issues the last offset (len-1), go to DRAIN.
  - DRAIN: one cycle, completes the final write, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Write path (registered):
  - wr_en and wr_addr are rd_addr delayed by one cycle, with wr_en=1 only for issued offsets.
  - wr_data is combinationally equal to rd_data.
- Timing for start at edge T with len=N>0:
  - Issues occur at cycles T+1..T+N.
  - Writes occur at T+2..T+N+1.
  - done is high at T+N+2.
  - busy is high T+1..T+N+1.
- len==0: no rd/wr activity; done is high at T+1; busy stays 0.
- Wrap-around: len=2^ADDR_WIDTH issues offsets 0..2^ADDR_WIDTH-1. The counter is ADDR_WIDTH+1 bits, so there is no early termination.
- start outside IDLE is ignored, including in DONE.
- Back-to-back copies: a start accepted the cycle after done begins a new copy.
- abort=1 in RUN or DRAIN:
  - Next edge goes to IDLE.
  - wr_en is 0 from that edge.
  - No done pulse.
  - Writes already performed stay performed.
- abort in IDLE or DONE has no effect. abort and start together in IDLE: start wins.
- Base outputs hold their last latched values in IDLE.
- Reset mid-operation: all outputs go immediately to their reset values; no partial completion is signalled.

Optional Feature:
- Macro TVM_MMAP_COPY_CHECKSUM_EN.
- When defined:
  - Adds output checksum, DATA_WIDTH bits.
  - checksum is a wrapping modulo-2^DATA_WIDTH sum of every wr_data written with wr_en=1.
  - It clears to 0 on accepted start and on reset.
  - It is stable from the done cycle until the next start.
- When undefined: no port, no logic.

Decomposition:
- Package tvm_mmap_pkg holds:
  - The state enum (IDLE, RUN, DRAIN, DONE).
  - The len clamp constant, computed as a function of ADDR_WIDTH.
- One natural sub-module, tvm_mmap_addr_gen. It contains the offset counter, the remaining-count counter and the one-cycle write-address/enable delay stage. The FSM stays in the top module.

Test Plan:
- src_base=0x1000, dst_base=0x2000, len=4, source units [0x11,0x22,0x33,0x44]:
  - wr_en high 4 cycles, wr_addr 0..3, data matches source.
  - done at T+6.
  - With CHECKSUM_EN, checksum=0xAA.
- len=0: done at T+1, wr_en never high, busy never high.
- len=256, ADDR_WIDTH=8: 256 writes, wr_addr wraps 0..255, done at T+258.
- abort asserted at T+3 with len=8: exactly 2 writes (offsets 0,1), no done, busy low after abort edge.
- start pulsed during RUN of len=5 copy: ignored. A second start the cycle after done (len=2, new bases) gives 2 writes to the new wr_mmap_addr.
- rst deasserted-low mid-RUN of len=6: outputs immediately 0. After release, a fresh start with len=1 completes normally, done at T+3.
